spi_bubble_buffer_loader: RTL and testbench
===========================================

Name: spi_bubble_buffer_loader

Overview:
- Upstream stage of the bubble interface. Fills its 2048x2-bit output buffer from an external SPI NOR flash.
- Starts a load on the falling edge of load_page or load_bootloader, which the bubble interface drives. Issues a flash READ (0x03) and writes each received 2-bit pair into the buffer through the buffer write port.
- Runs entirely on master_clock (48 MHz).

Parameters:
SCK_HALF, 2, SCK half-period in master_clock cycles (2 -> 12 MHz SCK)
BOOTLOADER_BASE, 24'h000000, flash byte address of bootloader image
PAGE_BASE, 24'h000200, flash byte address of page 0
PAGE_BYTES, 128, bytes per page (512 buffer entries)
BOOTLOADER_BYTES, 480, bytes per bootloader image (1920 buffer entries)

Ports:
master_clock  in  1  48 MHz clock; all logic on posedge
reset  in  1  synchronous, active-high
bubble_module_enable  in  1  active low; when high, new requests are ignored
load_page  in  1  active low from bubble interface; falling edge = page request
load_bootloader  in  1  active low; falling edge = bootloader request
page_number  in  11  page index, sampled on the request edge
spi_cs_n  out  1  flash chip select, active low
spi_sck  out  1  SPI clock, mode 0, idle low
spi_mosi  out  1  command/address bits, MSB first
spi_miso  in  1  flash data
bubble_buffer_write_address  out  11  buffer entry address
bubble_buffer_write_data_input  out  2  entry data; [1]=odd channel, [0]=even channel
bubble_buffer_write_enable  out  1  active low
bubble_buffer_write_clock  out  1  buffer write strobe; buffer writes on its rising edge
loader_busy  out  1  high from request accept until DONE or abort

Behaviour:
- Reset values: spi_cs_n=1, spi_sck=0, spi_mosi=0, write_address=0, write_data=0, write_enable=1, write_clock=0, loader_busy=0, state=IDLE.
- Edge detect: registered copies of load_page and load_bootloader, both reset to 1. Falling edge = prev 1 and current 0.
- IDLE:
  - Request accepted only when bubble_module_enable=0.
  - Simultaneous edges: bootloader wins.
  - Latch flash start address: bootloader -> BOOTLOADER_BASE; page -> PAGE_BASE + page_number*PAGE_BYTES (24-bit, wraps mod 2^24).
  - Latch byte count and which request is active. write_address := 0, loader_busy := 1.
  - Next cycle: spi_cs_n := 0, go to CMD.
- CMD: shift 8'h03. ADDR: shift 24-bit address. DATA: receive bytes.
- SCK timing:
  - Each bit lasts 2*SCK_HALF cycles: SCK low half then high half.
  - MOSI updates at the start of the low half.
  - MISO is sampled on the cycle SCK rises.
  - First SCK rise occurs SCK_HALF cycles after CS falls.
- DATA:
  - Bits shift MSB first. Every 2nd sampled bit forms a pair {first,second}.
  - Byte 0xB4 yields entries 2'b10, 2'b11, 2'b01, 2'b00 at consecutive addresses.
- Write sequence per pair (runs concurrently with SCK):
  - Cycle+1: address/data valid, enable=0.
  - Cycle+2: write_clock=1.
  - Cycle+3: write_clock=0, enable=1, address increments.
  - The sequence must finish before the next pair is sampled; this holds for SCK_HALF>=2.
  - Address after the final write equals the entry count: 512 or 1920. No address wrap is permitted at the default sizes.
- Completion: after the last pair's write completes, spi_cs_n := 1 and spi_sck := 0, then go to DONE with loader_busy := 0.
- DONE: wait until the active load signal returns high, then go to IDLE. No retrigger inside DONE.
- Abort:
  - Trigger: the active load signal returns high while in CMD, ADDR or DATA.
  - Next cycle: cs_n=1, sck=0, enable=1, write_clock=0, busy=0, state=IDLE.
  - An in-flight write sequence is cancelled.
- Requests arriving while busy or in DONE are ignored.
- bubble_module_enable going high mid-load does not abort the load.
- Reset mid-operation returns all outputs to their reset values on the next edge.
- Total SCK pulses per load: page 32+1024=1056 (4224 master cycles at default); bootloader 32+3840=3872.

Test Plan:
- Reset held 3 cycles, then released -> all outputs at reset values; no SCK activity.
- page_number=5, load_page falls -> MOSI bytes 03 00 04 80; 1056 SCK pulses; 512 writes at addresses 0..511; busy low after the last write; cs_n high.
- Flash model returns 0xB4 first -> entries at addresses 0..3 = 10, 11, 01, 00; each write shows enable low for 2 cycles and a single write_clock high cycle.
- load_bootloader falls -> address bytes 00 00 00; 1920 writes; last address 1919 (0x77F); 3872 SCK pulses.
- load_page and load_bootloader fall in the same cycle -> bootloader load performed. Raising load_page mid-DATA has no effect; raising load_bootloader after 100 writes -> abort next cycle, no further writes, cs_n=1.
- bubble_module_enable=1 with a load_page falling edge -> no CS activity, busy stays 0. Reset asserted mid-ADDR -> outputs at reset values next cycle.

Source files
------------

// File: rtl/spi_bubble_buffer_loader.sv
// Loads bubble buffer entries from SPI NOR flash (READ 0x03, mode 0) on a falling load request; ~4*SCK_HALF cycles per entry pair.
// No backpressure: the buffer write port is fire-and-forget, and a raised load signal aborts the transfer on the next edge.
module spi_bubble_buffer_loader #(
  parameter int          SCK_HALF         = 2,
  parameter logic [23:0] BOOTLOADER_BASE  = 24'h000000,
  parameter logic [23:0] PAGE_BASE        = 24'h000200,
  parameter int          PAGE_BYTES       = 128,
  parameter int          BOOTLOADER_BYTES = 480
) (
  input  logic        master_clock,
  input  logic        reset,
  input  logic        bubble_module_enable,
  input  logic        load_page,
  input  logic        load_bootloader,
  input  logic [10:0] page_number,
  output logic        spi_cs_n,
  output logic        spi_sck,
  output logic        spi_mosi,
  input  logic        spi_miso,
  output logic [10:0] bubble_buffer_write_address,
  output logic [1:0]  bubble_buffer_write_data_input,
  output logic        bubble_buffer_write_enable,
  output logic        bubble_buffer_write_clock,
  output logic        loader_busy
);

  typedef enum logic [2:0] {IDLE, START, CMD, ADDR, DATA, FINISH, DONE} state_t;

  typedef struct packed {
    logic        is_boot;
    logic [11:0] pairs;
  } load_req_t;

  localparam logic [7:0]  RISE_AT    = 8'(SCK_HALF - 1);
  localparam logic [7:0]  BIT_END    = 8'(2 * SCK_HALF - 1);
  localparam logic [11:0] PAGE_PAIRS = 12'(PAGE_BYTES * 4);
  localparam logic [11:0] BOOT_PAIRS = 12'(BOOTLOADER_BYTES * 4);

  state_t      state;
  load_req_t   req;
  logic        load_page_q;
  logic        load_bootloader_q;
  logic [31:0] shift_q;
  logic [7:0]  phase_q;
  logic [4:0]  bit_cnt_q;
  logic [11:0] pair_cnt_q;
  logic        half_q;
  logic        first_bit_q;
  logic [1:0]  wr_phase_q;

  logic        page_fall;
  logic        boot_fall;
  logic        active_high;
  logic        in_load;
  logic        sck_rise;
  logic        bit_end;
  logic [23:0] page_addr;

  assign page_fall   = load_page_q & ~load_page;
  assign boot_fall   = load_bootloader_q & ~load_bootloader;
  assign active_high = req.is_boot ? load_bootloader : load_page;
  assign in_load     = state inside {START, CMD, ADDR, DATA, FINISH};
  assign sck_rise    = (phase_q == RISE_AT);
  assign bit_end     = (phase_q == BIT_END);
  assign page_addr   = PAGE_BASE + 24'(page_number) * 24'(PAGE_BYTES);

  always_ff @(posedge master_clock) begin
    if (reset) begin
      state                          <= IDLE;
      req                            <= '0;
      load_page_q                    <= 1'b1;
      load_bootloader_q              <= 1'b1;
      shift_q                        <= '0;
      phase_q                        <= '0;
      bit_cnt_q                      <= '0;
      pair_cnt_q                     <= '0;
      half_q                         <= 1'b0;
      first_bit_q                    <= 1'b0;
      wr_phase_q                     <= '0;
      spi_cs_n                       <= 1'b1;
      spi_sck                        <= 1'b0;
      spi_mosi                       <= 1'b0;
      bubble_buffer_write_address    <= '0;
      bubble_buffer_write_data_input <= '0;
      bubble_buffer_write_enable     <= 1'b1;
      bubble_buffer_write_clock      <= 1'b0;
      loader_busy                    <= 1'b0;
    end else begin
      load_page_q       <= load_page;
      load_bootloader_q <= load_bootloader;

      if (in_load && active_high) begin
        state                      <= IDLE;
        wr_phase_q                 <= '0;
        spi_cs_n                   <= 1'b1;
        spi_sck                    <= 1'b0;
        bubble_buffer_write_enable <= 1'b1;
        bubble_buffer_write_clock  <= 1'b0;
        loader_busy                <= 1'b0;
      end else begin
        // Buffer write strobe runs in the background while SCK keeps toggling.
        case (wr_phase_q)
          2'd1: begin
            bubble_buffer_write_clock <= 1'b1;
            wr_phase_q                <= 2'd2;
          end
          2'd2: begin
            bubble_buffer_write_clock   <= 1'b0;
            bubble_buffer_write_enable  <= 1'b1;
            bubble_buffer_write_address <= bubble_buffer_write_address + 11'd1;
            wr_phase_q                  <= 2'd0;
          end
          default: ;
        endcase

        if (state inside {CMD, ADDR, DATA, FINISH}) begin
          phase_q <= bit_end ? 8'd0 : phase_q + 8'd1;
          if (sck_rise && state != FINISH) spi_sck <= 1'b1;
          if (bit_end) spi_sck <= 1'b0;
        end

        case (state)
          IDLE: begin
            if (!bubble_module_enable && (boot_fall || page_fall)) begin
              req.is_boot                 <= boot_fall;
              req.pairs                   <= boot_fall ? BOOT_PAIRS : PAGE_PAIRS;
              shift_q                     <= {8'h03, boot_fall ? BOOTLOADER_BASE : page_addr};
              bubble_buffer_write_address <= '0;
              loader_busy                 <= 1'b1;
              state                       <= START;
            end
          end
          START: begin
            spi_cs_n  <= 1'b0;
            spi_mosi  <= shift_q[31];
            shift_q   <= shift_q << 1;
            phase_q   <= '0;
            bit_cnt_q <= '0;
            state     <= CMD;
          end
          CMD, ADDR: begin
            if (bit_end) begin
              bit_cnt_q <= bit_cnt_q + 5'd1;
              if (bit_cnt_q == 5'd7) state <= ADDR;
              if (bit_cnt_q == 5'd31) begin
                state      <= DATA;
                spi_mosi   <= 1'b0;
                half_q     <= 1'b0;
                pair_cnt_q <= '0;
              end else begin
                spi_mosi <= shift_q[31];
                shift_q  <= shift_q << 1;
              end
            end
          end
          DATA: begin
            if (sck_rise) begin
              if (!half_q) begin
                first_bit_q <= spi_miso;
                half_q      <= 1'b1;
              end else begin
                half_q                         <= 1'b0;
                bubble_buffer_write_data_input <= {first_bit_q, spi_miso};
                bubble_buffer_write_enable     <= 1'b0;
                wr_phase_q                     <= 2'd1;
                pair_cnt_q                     <= pair_cnt_q + 12'd1;
                if (pair_cnt_q == req.pairs - 12'd1) state <= FINISH;
              end
            end
          end
          FINISH: begin
            // Chip select stays low until the final buffer write has retired.
            if (wr_phase_q == 2'd0) begin
              spi_cs_n    <= 1'b1;
              spi_sck     <= 1'b0;
              loader_busy <= 1'b0;
              state       <= DONE;
            end
          end
          DONE: begin
            if (active_high) state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_bubble_buffer_loader.sv
// Directed bench for spi_bubble_buffer_loader with a behavioural SPI flash returning a fixed byte pattern (byte 0 = 0xB4).
module tb_spi_bubble_buffer_loader;

  logic        master_clock = 1'b0;
  logic        reset = 1'b1;
  logic        bubble_module_enable = 1'b0;
  logic        load_page = 1'b1;
  logic        load_bootloader = 1'b1;
  logic [10:0] page_number = '0;
  logic        spi_cs_n;
  logic        spi_sck;
  logic        spi_mosi;
  logic        spi_miso;
  logic [10:0] bubble_buffer_write_address;
  logic [1:0]  bubble_buffer_write_data_input;
  logic        bubble_buffer_write_enable;
  logic        bubble_buffer_write_clock;
  logic        loader_busy;

  spi_bubble_buffer_loader dut (
    .master_clock                   (master_clock),
    .reset                          (reset),
    .bubble_module_enable           (bubble_module_enable),
    .load_page                      (load_page),
    .load_bootloader                (load_bootloader),
    .page_number                    (page_number),
    .spi_cs_n                       (spi_cs_n),
    .spi_sck                        (spi_sck),
    .spi_mosi                       (spi_mosi),
    .spi_miso                       (spi_miso),
    .bubble_buffer_write_address    (bubble_buffer_write_address),
    .bubble_buffer_write_data_input (bubble_buffer_write_data_input),
    .bubble_buffer_write_enable     (bubble_buffer_write_enable),
    .bubble_buffer_write_clock      (bubble_buffer_write_clock),
    .loader_busy                    (loader_busy)
  );

  always #5 master_clock = ~master_clock;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] byte_at(input int n);
    if (n == 0) return 8'hB4;
    return 8'((n * 37 + 11) & 255);
  endfunction

  function automatic logic [1:0] exp_pair(input int e);
    logic [7:0] b;
    b = byte_at(e / 4);
    return 2'((b >> (6 - 2 * (e % 4))) & 8'd3);
  endfunction

  // Flash model: captures the 32 command/address bits, then streams the pattern MSB first.
  int          rise_cnt = 0;
  int          sck_cnt = 0;
  int          cs_fall_cnt = 0;
  int          bidx;
  logic [7:0]  cur_byte;
  logic [31:0] cmd_word = '0;

  always @(negedge spi_cs_n) begin
    rise_cnt = 0;
    cs_fall_cnt++;
  end

  always @(posedge spi_sck) begin
    sck_cnt++;
    if (!spi_cs_n) begin
      if (rise_cnt < 32) cmd_word = {cmd_word[30:0], spi_mosi};
      rise_cnt++;
    end
  end

  always_comb begin
    bidx     = (rise_cnt >= 32) ? rise_cnt - 32 : 0;
    cur_byte = byte_at(bidx / 8);
    spi_miso = (rise_cnt >= 32) ? cur_byte[7 - (bidx % 8)] : 1'b0;
  end

  // Buffer write monitor.
  int         wr_cnt = 0;
  int         last_addr = 0;
  int         en_low_cnt = 0;
  int         wclk_run = 0;
  logic       wclk_prev = 1'b0;
  logic [1:0] wr_data_log [0:2047];

  always @(negedge master_clock) begin
    if (bubble_buffer_write_clock && !wclk_prev) begin
      check("wr_addr", 32'(bubble_buffer_write_address), 32'(wr_cnt));
      check("wr_data", 32'(bubble_buffer_write_data_input), 32'(exp_pair(wr_cnt)));
      check("wr_en_at_strobe", 32'(bubble_buffer_write_enable), 32'd0);
      wr_data_log[wr_cnt % 2048] = bubble_buffer_write_data_input;
      last_addr = 32'(bubble_buffer_write_address);
      wr_cnt++;
    end
    if (bubble_buffer_write_clock) wclk_run++;
    else if (wclk_run != 0) begin
      check("wclk_width", 32'(wclk_run), 32'd1);
      wclk_run = 0;
    end
    if (!bubble_buffer_write_enable) en_low_cnt++;
    else if (en_low_cnt != 0) begin
      check("we_width", 32'(en_low_cnt), 32'd2);
      en_low_cnt = 0;
    end
    wclk_prev = bubble_buffer_write_clock;
  end

  task automatic check_idle(input string tag);
    check({tag, "_cs_n"}, 32'(spi_cs_n), 32'd1);
    check({tag, "_sck"}, 32'(spi_sck), 32'd0);
    check({tag, "_mosi"}, 32'(spi_mosi), 32'd0);
    check({tag, "_addr"}, 32'(bubble_buffer_write_address), 32'd0);
    check({tag, "_data"}, 32'(bubble_buffer_write_data_input), 32'd0);
    check({tag, "_we"}, 32'(bubble_buffer_write_enable), 32'd1);
    check({tag, "_wclk"}, 32'(bubble_buffer_write_clock), 32'd0);
    check({tag, "_busy"}, 32'(loader_busy), 32'd0);
  endtask

  task automatic wait_busy_low(input int limit, input string tag);
    int i = 0;
    while (loader_busy && i < limit) begin
      @(negedge master_clock);
      i++;
    end
    check(tag, 32'(loader_busy), 32'd0);
  endtask

  task automatic wait_writes(input int n, input int limit, input string tag);
    int i = 0;
    while (!(wr_cnt >= n && bubble_buffer_write_enable) && i < limit) begin
      @(negedge master_clock);
      i++;
    end
    check(tag, 32'(wr_cnt), 32'(n));
  endtask

  initial begin
    int cs_before;
    int sck_before;

    repeat (3) @(negedge master_clock);
    reset = 1'b0;
    repeat (5) @(negedge master_clock);
    check_idle("rst");
    check("rst_no_sck", 32'(sck_cnt), 32'd0);

    // Page 5 -> flash address 0x000480.
    sck_cnt = 0; wr_cnt = 0;
    page_number = 11'd5;
    load_page = 1'b0;
    @(negedge master_clock);
    check("page_busy", 32'(loader_busy), 32'd1);
    wait_busy_low(6000, "page_done");
    check("page_cmd", cmd_word, 32'h03000480);
    check("page_sck", 32'(sck_cnt), 32'd1056);
    check("page_writes", 32'(wr_cnt), 32'd512);
    check("page_last_addr", 32'(last_addr), 32'd511);
    check("page_final_addr", 32'(bubble_buffer_write_address), 32'd512);
    check("page_cs_n", 32'(spi_cs_n), 32'd1);
    check("b4_e0", 32'(wr_data_log[0]), 32'd2);
    check("b4_e1", 32'(wr_data_log[1]), 32'd3);
    check("b4_e2", 32'(wr_data_log[2]), 32'd1);
    check("b4_e3", 32'(wr_data_log[3]), 32'd0);
    load_page = 1'b1;
    repeat (4) @(negedge master_clock);

    // Bootloader image.
    sck_cnt = 0; wr_cnt = 0;
    load_bootloader = 1'b0;
    @(negedge master_clock);
    check("boot_busy", 32'(loader_busy), 32'd1);
    wait_busy_low(20000, "boot_done");
    check("boot_cmd", cmd_word, 32'h03000000);
    check("boot_sck", 32'(sck_cnt), 32'd3872);
    check("boot_writes", 32'(wr_cnt), 32'd1920);
    check("boot_last_addr", 32'(last_addr), 32'd1919);
    check("boot_final_addr", 32'(bubble_buffer_write_address), 32'd1920);
    load_bootloader = 1'b1;
    repeat (4) @(negedge master_clock);

    // Simultaneous request: bootloader wins; raising load_page is ignored, raising load_bootloader aborts.
    sck_cnt = 0; wr_cnt = 0;
    page_number = 11'd9;
    load_page = 1'b0;
    load_bootloader = 1'b0;
    wait_writes(50, 2000, "sim_50");
    load_page = 1'b1;
    wait_writes(100, 2000, "sim_100");
    check("sim_busy_before", 32'(loader_busy), 32'd1);
    load_bootloader = 1'b1;
    @(negedge master_clock);
    check("abort_cs_n", 32'(spi_cs_n), 32'd1);
    check("abort_sck", 32'(spi_sck), 32'd0);
    check("abort_we", 32'(bubble_buffer_write_enable), 32'd1);
    check("abort_wclk", 32'(bubble_buffer_write_clock), 32'd0);
    check("abort_busy", 32'(loader_busy), 32'd0);
    check("sim_cmd", cmd_word, 32'h03000000);
    sck_before = sck_cnt;
    repeat (100) @(negedge master_clock);
    check("abort_no_writes", 32'(wr_cnt), 32'd100);
    check("abort_no_sck", 32'(sck_cnt), 32'(sck_before));
    check("abort_cs_stays", 32'(spi_cs_n), 32'd1);

    // Module disabled: request ignored.
    cs_before = cs_fall_cnt;
    bubble_module_enable = 1'b1;
    load_page = 1'b0;
    repeat (50) @(negedge master_clock);
    check("dis_busy", 32'(loader_busy), 32'd0);
    check("dis_cs", 32'(cs_fall_cnt), 32'(cs_before));
    load_page = 1'b1;
    @(negedge master_clock);
    bubble_module_enable = 1'b0;
    repeat (3) @(negedge master_clock);

    // Reset during the address phase.
    sck_cnt = 0;
    page_number = 11'd3;
    load_page = 1'b0;
    begin
      int i = 0;
      while (sck_cnt < 12 && i < 200) begin
        @(negedge master_clock);
        i++;
      end
    end
    check("midaddr_reached", 32'(sck_cnt >= 12), 32'd1);
    check("midaddr_busy", 32'(loader_busy), 32'd1);
    reset = 1'b1;
    @(negedge master_clock);
    check_idle("midaddr_rst");
    load_page = 1'b1;
    @(negedge master_clock);
    reset = 1'b0;
    sck_before = sck_cnt;
    repeat (20) @(negedge master_clock);
    check("post_rst_busy", 32'(loader_busy), 32'd0);
    check("post_rst_sck", 32'(sck_cnt), 32'(sck_before));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
